// File: rtl/conv_bus_pkg.sv
// -----------------------------------------------------------------------------
// conv_bus_pkg
// Shared definitions for the convolution accelerator bus: the master FSM state
// encoding, the 2-bit iobus control codes, and the word-counter width helper.
// Imported by the bus master, its interface and the accelerator-side decode.
// -----------------------------------------------------------------------------
package conv_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_W   = 3'd1,
        ST_LOAD_I   = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_READ     = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    typedef logic [1:0] ctrl_t;

    localparam ctrl_t CTRL_NOP  = 2'b00;
    localparam ctrl_t CTRL_WR_W = 2'b01;
    localparam ctrl_t CTRL_WR_I = 2'b10;
    localparam ctrl_t CTRL_RD   = 2'b11;

    // Default number of words per weight set / image window.
    localparam int N_INPUT_DFLT = 9;

    // Word counter must hold 0..n_input.
    function automatic int wcnt_width(input int n_input);
        return $clog2(n_input + 1);
    endfunction

endpackage

// File: rtl/conv_bus_master_if.sv
// -----------------------------------------------------------------------------
// conv_bus_master_if
// Groups the streaming handshakes and the accelerator control handshake seen
// by conv_bus_master. Signal names carry the master's direction prefix.
//   weight stream : i_w_data, i_w_val, o_w_rdy
//   image stream  : i_img_data, i_img_val, o_img_rdy
//   accelerator   : o_ctrl, i_wreq, i_ireq, i_val
//   result stream : o_res_data, o_res_val, i_res_rdy
// The shared tri-state iobus itself stays a plain inout port of the master.
// -----------------------------------------------------------------------------
interface conv_bus_master_if
    import conv_bus_pkg::*;
#(
    parameter int BUS_WIDTH = 32
) ();

    logic [BUS_WIDTH-1:0] i_w_data;
    logic                 i_w_val;
    logic                 o_w_rdy;

    logic [BUS_WIDTH-1:0] i_img_data;
    logic                 i_img_val;
    logic                 o_img_rdy;

    ctrl_t                o_ctrl;
    logic                 i_wreq;
    logic                 i_ireq;
    logic                 i_val;

    logic [BUS_WIDTH-1:0] o_res_data;
    logic                 o_res_val;
    logic                 i_res_rdy;

    modport master (
        input  i_w_data, i_w_val,
        output o_w_rdy,
        input  i_img_data, i_img_val,
        output o_img_rdy,
        output o_ctrl,
        input  i_wreq, i_ireq, i_val,
        output o_res_data, o_res_val,
        input  i_res_rdy
    );

    modport slave (
        output i_w_data, i_w_val,
        input  o_w_rdy,
        output i_img_data, i_img_val,
        input  o_img_rdy,
        input  o_ctrl,
        output i_wreq, i_ireq, i_val,
        input  o_res_data, o_res_val,
        output i_res_rdy
    );

endinterface

// File: rtl/conv_bus_master.sv
// -----------------------------------------------------------------------------
// conv_bus_master
// Host-side initiator for the convolution accelerator's shared tri-state bus.
// Streams an optional weight set and N_INPUT image words per window onto iobus,
// waits for the accelerator's result-valid flag, turns the bus around for a
// single result-read cycle and hands the sum out on a one-entry result stream.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_start           : start pulse, honoured only in IDLE
//   i_n_win           : number of windows (0 behaves as 1), latched at start
//   i_load_w          : send a weight set before the first window
//   bus (master)      : weight/image/result streams + accelerator handshake
//   iobus             : shared tri-state data bus
//   o_busy            : high in every state except IDLE
//   o_done            : one-cycle pulse after the last window's read
//   o_err             : one-cycle pulse when result-valid never arrived
// -----------------------------------------------------------------------------
module conv_bus_master
    import conv_bus_pkg::*;
#(
    parameter int BUS_WIDTH = 32,
    parameter int N_INPUT   = N_INPUT_DFLT,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [15:0]          i_n_win,
    input  logic                 i_load_w,
    conv_bus_master_if.master    bus,
    inout  wire  [BUS_WIDTH-1:0] iobus,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    localparam int CNT_W = wcnt_width(N_INPUT);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_INPUT - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);

    state_e               state_q,    state_d;
    logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
    logic [15:0]          win_cnt_q,  win_cnt_d;
    logic [WD_W-1:0]      wdog_q,     wdog_d;
    logic [BUS_WIDTH-1:0] res_data_q, res_data_d;
    logic                 res_val_q,  res_val_d;
    logic                 err_q,      err_d;
    logic                 busy_q;
    logic                 done_q;

    ctrl_t                ctrl_s;
    logic                 drive_s;
    logic [BUS_WIDTH-1:0] bus_out_s;
    logic                 w_rdy_s;
    logic                 img_rdy_s;
    logic                 last_word_s;

    assign last_word_s = (word_cnt_q == LAST_WORD);

    // Next-state, counters and combinational bus/handshake outputs.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        win_cnt_d  = win_cnt_q;
        wdog_d     = wdog_q;
        res_data_d = res_data_q;
        // Result register empties when the consumer takes it.
        res_val_d  = res_val_q & ~bus.i_res_rdy;
        err_d      = 1'b0;
        ctrl_s     = CTRL_NOP;
        drive_s    = 1'b0;
        bus_out_s  = {BUS_WIDTH{1'b0}};
        w_rdy_s    = 1'b0;
        img_rdy_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    win_cnt_d  = (i_n_win == 16'd0) ? 16'd1 : i_n_win;
                    word_cnt_d = {CNT_W{1'b0}};
                    wdog_d     = {WD_W{1'b0}};
                    if (i_load_w) begin
                        state_d = ST_LOAD_W;
                    end else begin
                        state_d = ST_LOAD_I;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LOAD_W: begin
                w_rdy_s = bus.i_wreq;
                if (bus.i_w_val && bus.i_wreq) begin
                    ctrl_s    = CTRL_WR_W;
                    drive_s   = 1'b1;
                    bus_out_s = bus.i_w_data;
                    if (last_word_s) begin
                        word_cnt_d = {CNT_W{1'b0}};
                        state_d    = ST_LOAD_I;
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end else begin
                    ctrl_s = CTRL_NOP;
                end
            end

            ST_LOAD_I: begin
                img_rdy_s = bus.i_ireq;
                if (bus.i_img_val && bus.i_ireq) begin
                    ctrl_s    = CTRL_WR_I;
                    drive_s   = 1'b1;
                    bus_out_s = bus.i_img_data;
                    if (last_word_s) begin
                        word_cnt_d = {CNT_W{1'b0}};
                        wdog_d     = {WD_W{1'b0}};
                        state_d    = ST_WAIT_RES;
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end else begin
                    ctrl_s = CTRL_NOP;
                end
            end

            ST_WAIT_RES: begin
                // While the result register is still full, hold here with the
                // watchdog frozen: the delay is the consumer's, not the
                // accelerator's.
                if (!res_val_q) begin
                    if (bus.i_val) begin
                        wdog_d  = {WD_W{1'b0}};
                        state_d = ST_READ;
                    end else if (wdog_q == WD_LAST) begin
                        wdog_d  = {WD_W{1'b0}};
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        wdog_d = wdog_q + WD_W'(1);
                    end
                end else begin
                    wdog_d = wdog_q;
                end
            end

            ST_READ: begin
                // Bus released; the accelerator drives the sum this cycle.
                ctrl_s     = CTRL_RD;
                res_data_d = iobus;
                res_val_d  = 1'b1;
                win_cnt_d  = win_cnt_q - 16'd1;
                if (win_cnt_q == 16'd1) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOAD_I;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters, result register and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= {CNT_W{1'b0}};
            win_cnt_q  <= 16'd0;
            wdog_q     <= {WD_W{1'b0}};
            res_data_q <= {BUS_WIDTH{1'b0}};
            res_val_q  <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            win_cnt_q  <= win_cnt_d;
            wdog_q     <= wdog_d;
            res_data_q <= res_data_d;
            res_val_q  <= res_val_d;
            err_q      <= err_d;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
        end
    end

    // Drive the shared bus only during a write transfer.
    assign iobus = drive_s ? bus_out_s : {BUS_WIDTH{1'bz}};

    assign bus.o_ctrl     = ctrl_s;
    assign bus.o_w_rdy    = w_rdy_s;
    assign bus.o_img_rdy  = img_rdy_s;
    assign bus.o_res_data = res_data_q;
    assign bus.o_res_val  = res_val_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_err          = err_q;

endmodule

// File: tb/tb_conv_bus_master.sv
// -----------------------------------------------------------------------------
// tb_conv_bus_master
// Randomized bench for conv_bus_master (N_INPUT=3, TIMEOUT=16). The bench
// plays the upstream streams, the result consumer and a dot-product
// accelerator that listens on iobus. Expected sums come from the source data.
// -----------------------------------------------------------------------------
module tb_conv_bus_master;
    import conv_bus_pkg::*;

    localparam int BW = 32;
    localparam int NI = 3;
    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [15:0] i_n_win;
    logic        i_load_w;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    wire [BW-1:0] iobus;

    conv_bus_master_if #(.BUS_WIDTH(BW)) bus ();

    conv_bus_master #(.BUS_WIDTH(BW), .N_INPUT(NI), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_start),
        .i_n_win (i_n_win),
        .i_load_w(i_load_w),
        .bus     (bus.master),
        .iobus   (iobus),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_err   (o_err)
    );

    int errors;
    int checks;
    int cyc;

    logic [BW-1:0] w_src_q[$];
    logic [BW-1:0] i_src_q[$];
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] ref_w   [NI];
    logic [BW-1:0] acc_w   [NI];
    logic [BW-1:0] acc_img [NI];
    int            acc_wc, acc_ic, acc_lat;
    logic          acc_has;
    logic [BW-1:0] acc_res;

    int   n01, n10, n11, done_seen, err_seen, win_end_cyc;
    int   cur_nw, cur_wtot, val_mode, rdy_hold, rst_img;
    logic never_val, junk_start, tog, aborted;
    ctrl_t prev_ctrl;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accelerator drives the held result during a result-read cycle.
    assign iobus = (bus.o_ctrl == CTRL_RD && acc_has) ? acc_res : {BW{1'bz}};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ctrl"},    bus.o_ctrl,     CTRL_NOP);
        check_val({tag, "_wrdy"},    bus.o_w_rdy,    1'b0);
        check_val({tag, "_irdy"},    bus.o_img_rdy,  1'b0);
        check_val({tag, "_resval"},  bus.o_res_val,  1'b0);
        check_val({tag, "_resdata"}, bus.o_res_data, 32'd0);
        check_val({tag, "_busy"},    o_busy,         1'b0);
        check_val({tag, "_done"},    o_done,         1'b0);
        check_val({tag, "_err"},     o_err,          1'b0);
    endtask

    // One clock: sample and check at negedge, then update models and drive.
    task automatic cycle();
        logic          w_x, i_x, r_x;
        ctrl_t         c;
        logic [BW-1:0] bv;
        @(negedge clk);
        cyc++;
        c   = bus.o_ctrl;
        bv  = iobus;
        w_x = bus.i_w_val && bus.o_w_rdy;
        i_x = bus.i_img_val && bus.o_img_rdy;
        r_x = bus.o_res_val && bus.i_res_rdy;

        if (rst_img >= 0 && i_x && acc_ic == rst_img) begin
            rst_n = 1'b0;
            #1;
            check_reset_outputs("midrst");
            aborted = 1'b1;
            return;
        end

        check_val("ctrl_wr_w", c == CTRL_WR_W, w_x);
        check_val("ctrl_wr_i", c == CTRL_WR_I, i_x);
        check_val("wrdy_needs_req", bus.o_w_rdy && !bus.i_wreq, 1'b0);
        check_val("irdy_needs_req", bus.o_img_rdy && !bus.i_ireq, 1'b0);
        if (n01 >= cur_wtot) check_val("wrdy_off", bus.o_w_rdy, 1'b0);
        if (!o_busy) check_val("idle_quiet", {bus.o_w_rdy, bus.o_img_rdy, bus.o_ctrl}, 4'd0);
        if (w_x) begin
            check_val("w_word", bv, w_src_q.size() > 0 ? w_src_q[0] : ~bv);
            n01++;
        end
        if (i_x) begin
            check_val("i_word", bv, i_src_q.size() > 0 ? i_src_q[0] : ~bv);
            n10++;
        end
        if (c == CTRL_RD) begin
            n11++;
            check_val("rd_turnaround", prev_ctrl == CTRL_WR_I, 1'b0);
            check_val("rd_reg_empty", bus.o_res_val, 1'b0);
            check_val("rd_has_result", acc_has, 1'b1);
        end
        if (r_x) begin
            if (exp_q.size() == 0) begin
                check_val("res_extra", 1'b1, 1'b0);
            end else begin
                check_val("res_data", bus.o_res_data, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
        if (o_done) begin
            done_seen++;
            check_val("done_after_reads", n11, cur_nw);
        end
        if (never_val) begin
            if (o_err) begin
                err_seen++;
                check_val("err_timing", cyc - win_end_cyc, TO + 1);
            end
        end else begin
            check_val("no_err", o_err, 1'b0);
        end
        prev_ctrl = c;

        @(posedge clk);
        #1;
        if (w_x) void'(w_src_q.pop_front());
        if (i_x) void'(i_src_q.pop_front());
        // Accelerator model: collects words it sees on the bus.
        if (c == CTRL_WR_W) begin
            acc_w[acc_wc] = bv;
            acc_wc = (acc_wc + 1) % NI;
        end
        if (c == CTRL_WR_I) begin
            acc_img[acc_ic] = bv;
            acc_ic++;
            if (acc_ic == NI) begin
                acc_ic  = 0;
                acc_res = '0;
                for (int i = 0; i < NI; i++) acc_res = acc_res + acc_w[i] * acc_img[i];
                acc_has     = 1'b1;
                acc_lat     = never_val ? -1 : int'($urandom_range(0, 4));
                win_end_cyc = cyc;
            end
        end
        if (c == CTRL_RD) begin
            acc_has   = 1'b0;
            bus.i_val = 1'b0;
        end
        if (acc_has && !bus.i_val) begin
            if (acc_lat == 0) bus.i_val = 1'b1;
            else if (acc_lat > 0) acc_lat--;
        end

        bus.i_wreq = (val_mode != 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        bus.i_ireq = (val_mode != 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        bus.i_w_val  = (w_src_q.size() > 0) && (val_mode == 2 || $urandom_range(0, 3) != 0);
        bus.i_w_data = (w_src_q.size() > 0) ? w_src_q[0] : BW'($urandom);
        tog = ~tog;
        if (val_mode == 1) bus.i_img_val = (i_src_q.size() > 0) && tog;
        else bus.i_img_val = (i_src_q.size() > 0) && (val_mode == 2 || $urandom_range(0, 3) != 0);
        bus.i_img_data = (i_src_q.size() > 0) ? i_src_q[0] : BW'($urandom);
        if (rdy_hold > 0) begin
            bus.i_res_rdy = 1'b0;
            if (bus.o_res_val) rdy_hold--;
        end else begin
            bus.i_res_rdy = ($urandom_range(0, 1) == 1);
        end
        // Start pulses while busy must be ignored.
        i_start = junk_start && o_busy && ($urandom_range(0, 7) == 0);
        if (i_start) begin
            i_n_win  = 16'($urandom);
            i_load_w = ($urandom_range(0, 1) == 1);
        end
    endtask

    task automatic run_job(input logic lw, input logic [15:0] nwin, input int vmode, input int hold,
                           input logic never, input int rimg, input logic fixed);
        int            nw;
        int            budget;
        logic          fin;
        logic [BW-1:0] v;
        logic [BW-1:0] s;
        nw = (nwin == 16'd0) ? 1 : int'(nwin);
        w_src_q.delete();
        i_src_q.delete();
        exp_q.delete();
        if (lw) begin
            for (int i = 0; i < NI; i++) begin
                ref_w[i] = fixed ? BW'(i + 1) : BW'($urandom_range(0, 255));
                w_src_q.push_back(ref_w[i]);
            end
        end
        for (int k = 0; k < nw; k++) begin
            s = '0;
            for (int i = 0; i < NI; i++) begin
                v = fixed ? BW'(i + 4) : BW'($urandom_range(0, 255));
                i_src_q.push_back(v);
                s = s + ref_w[i] * v;
            end
            if (!never) exp_q.push_back(s);
        end
        n01 = 0; n10 = 0; n11 = 0; done_seen = 0; err_seen = 0;
        cur_nw = never ? 0 : nw;
        cur_wtot = lw ? NI : 0;
        acc_ic = 0; acc_wc = 0; acc_has = 1'b0; bus.i_val = 1'b0;
        aborted = 1'b0; val_mode = vmode; rdy_hold = hold; never_val = never;
        rst_img = rimg; prev_ctrl = CTRL_NOP; junk_start = 1'b1;
        i_start = 1'b1; i_n_win = nwin; i_load_w = lw;
        budget = 800;
        fin = 1'b0;
        while (budget > 0 && !fin) begin
            cycle();
            budget--;
            fin = aborted || ((done_seen > 0 || err_seen > 0) && exp_q.size() == 0);
        end
        check_val("job_finished", fin, 1'b1);
        junk_start = 1'b0;
        if (aborted) begin
            @(posedge clk);
            #1;
            bus.i_w_val = 1'b0; bus.i_img_val = 1'b0; bus.i_val = 1'b0;
            acc_has = 1'b0; acc_ic = 0; i_start = 1'b0; rst_img = -1;
            rst_n = 1'b1;
        end else begin
            i_start = 1'b0;
            repeat (3) cycle();
            check_val("n_wr_w", n01, lw ? NI : 0);
            check_val("n_wr_i", n10, NI * nw);
            check_val("n_rd", n11, never ? 0 : nw);
            check_val("done_once", done_seen, never ? 0 : 1);
            check_val("err_once", err_seen, never ? 1 : 0);
            check_val("busy_end", o_busy, 1'b0);
            check_val("results_left", exp_q.size(), 0);
            check_val("images_left", i_src_q.size(), 0);
        end
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0;
        rst_n = 1'b1; i_start = 1'b0; i_n_win = 16'd0; i_load_w = 1'b0;
        junk_start = 1'b0; tog = 1'b0; aborted = 1'b0; never_val = 1'b0;
        val_mode = 2; rdy_hold = 0; rst_img = -1; prev_ctrl = CTRL_NOP;
        n01 = 0; n10 = 0; n11 = 0; done_seen = 0; err_seen = 0;
        cur_nw = 0; cur_wtot = 0; win_end_cyc = 0;
        acc_wc = 0; acc_ic = 0; acc_lat = -1; acc_has = 1'b0; acc_res = '0;
        for (int i = 0; i < NI; i++) begin
            ref_w[i] = '0; acc_w[i] = '0; acc_img[i] = '0;
        end
        bus.i_w_data = '0; bus.i_w_val = 1'b0; bus.i_img_data = '0; bus.i_img_val = 1'b0;
        bus.i_wreq = 1'b0; bus.i_ireq = 1'b0; bus.i_val = 1'b0; bus.i_res_rdy = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Weights 1,2,3 and images 4,5,6: single window, sum 32.
        run_job(1'b1, 16'd1, 2, 0, 1'b0, -1, 1'b1);
        // Three windows on the loaded weights, random handshakes.
        run_job(1'b0, 16'd3, 0, 0, 1'b0, -1, 1'b0);
        // Image valid toggling every cycle.
        run_job(1'b0, 16'd1, 1, 0, 1'b0, -1, 1'b0);
        // Consumer stalls well past TIMEOUT while the second result is ready.
        run_job(1'b0, 16'd2, 2, 30, 1'b0, -1, 1'b0);
        // Result-valid never arrives.
        run_job(1'b0, 16'd1, 2, 0, 1'b1, -1, 1'b0);
        // Reset during the second image word, then a fresh run.
        run_job(1'b1, 16'd1, 2, 0, 1'b0, 1, 1'b0);
        run_job(1'b1, 16'd2, 0, 0, 1'b0, -1, 1'b0);
        // Window count of zero behaves as one.
        run_job(1'b0, 16'd0, 0, 0, 1'b0, -1, 1'b0);
        for (int j = 0; j < 4; j++) begin
            run_job($urandom_range(0, 1) == 1, 16'($urandom_range(1, 4)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 6)), 1'b0, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
